// File: rtl/sub_defs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sub_defs : shared state encodings and defaults for serial_subtractor |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sub_defs;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | full_subtractor : one-bit a - b - bin, combinational                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor : bit-serial unsigned a - b, LSB first             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serial_subtractor
  import sub_defs::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bf_q, bf_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step_diff;
  logic             step_bout;

  full_subtractor u_fs (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bin    (bf_q),
    .diff   (step_diff),
    .borrow (step_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result fills from the MSB so the final bit lands in place on the last step.
        res_d  = {step_diff, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bf_d   = step_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {step_diff, res_q[WIDTH-1:1]};
          borrow_d = step_bout;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor : directed self-checking bench, WIDTH 8 and 4   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start,  start4;
  logic [7:0] a, b, diff;
  logic [3:0] a4, b4, diff4;
  logic       busy, done, borrow;
  logic       busy4, done4, borrow4;

  int         n_checks;
  int         n_errors;
  logic [7:0] prev_diff;
  logic       prev_borrow;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; with disturb set, a/b churn and start is held during RUN and DONE.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input bit disturb);
    int lat;
    bit seen;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        lat++;
        if (lat == 1) begin
          chk({tag, "_held"}, 32'({diff, borrow}), 32'({prev_diff, prev_borrow}));
          chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        if (disturb) begin
          a = 8'($urandom); b = 8'($urandom); start = 1'b1;
        end
      end
    end
    chk({tag, "_seen"},   32'(seen),   32'd1);
    chk({tag, "_lat"},    32'(lat),    32'd8);
    chk({tag, "_diff"},   32'(diff),   32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    chk({tag, "_nbusy"},  32'(busy),   32'd0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    prev_diff   = ed;
    prev_borrow = eb;
  endtask

  initial begin
    int ndone, last, extra;
    n_checks = 0; n_errors = 0;
    prev_diff = 8'd0; prev_borrow = 1'b0;
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a = 8'd0; b = 8'd0; a4 = 4'd0; b4 = 4'd0;
    #2;
    chk("rst_out8", 32'({busy, done, diff, borrow}), 32'd0);
    chk("rst_out4", 32'({busy4, done4, diff4, borrow4}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op("t2_100_37", 8'd100, 8'd37, 8'd63,   1'b0, 1'b0);
    run_op("t3_5_9",    8'd5,   8'd9,  8'hFC,   1'b1, 1'b0);
    run_op("t3_0_1",    8'd0,   8'd1,  8'hFF,   1'b1, 1'b0);
    run_op("t3_ff_0",   8'hFF,  8'd0,  8'hFF,   1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears held results before any edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t1_async", 32'({busy, done, diff, borrow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_diff = 8'd0; prev_borrow = 1'b0;

    run_op("t3_ff_0b", 8'hFF, 8'd0, 8'hFF, 1'b0, 1'b0);
    run_op("t4_0_0",   8'd0,  8'd0, 8'd0,  1'b0, 1'b1);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || diff != 8'd0 || borrow) extra++;
    end
    chk("t4_quiet", 32'(extra), 32'd0);

    // Abort mid-RUN with reset.
    run_op("t5_pre", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'd200; b = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("t5_abort", 32'({busy, done, diff, borrow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("t5_nodone", 32'(extra), 32'd0);
    prev_diff = 8'd0; prev_borrow = 1'b0;
    run_op("t5_7_7", 8'd7, 8'd7, 8'd0, 1'b0, 1'b0);

    // Back-to-back, start held high: WIDTH=8 every 10 cycles.
    @(negedge clk);
    a = 8'd10; b = 8'd3; start = 1'b1;
    ndone = 0; last = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) chk("t6_first8", 32'(i), 32'd8);
        else            chk("t6_gap8", 32'(i - last), 32'd10);
        chk("t6_res8", 32'({diff, borrow}), 32'({8'd7, 1'b0}));
        last = i;
        ndone++;
      end
    end
    start = 1'b0;
    chk("t6_count8", 32'(ndone), 32'd4);

    // Back-to-back on WIDTH=4: every 6 cycles.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    ndone = 0; last = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done4) begin
        if (ndone == 0) chk("t6_first4", 32'(i), 32'd4);
        else            chk("t6_gap4", 32'(i - last), 32'd6);
        chk("t6_res4", 32'({diff4, borrow4}), 32'({4'hE, 1'b1}));
        last = i;
        ndone++;
      end
    end
    start4 = 1'b0;
    chk("t6_count4", 32'(ndone), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
